// File: rtl/exe_stage.sv
// Execute stage of the five-stage MIPS pipeline: ALU, link/effective address,
// HI/LO with single-cycle multiplier and restoring divider, data-SRAM request.
//
// state | meaning
// IDLE  | no divide in flight (also the state a new divide starts from)
// BUSY  | restoring divide, one quotient bit per cycle, counter 0..31
// DONE  | quotient/remainder ready, held until the instruction leaves
module exe_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         ms_allowin,
    output logic         es_allowin,
    input  logic         ds_to_es_valid,
    input  logic [154:0] ds_to_es_bus,
    output logic         es_to_ms_valid,
    output logic [78:0]  es_to_ms_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic [38:0]  es_fwd_bus,
    output logic         es_valid
);

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    logic [154:0] es_bus;
    logic         es_ready_go;
    logic         es_leave;

    logic [11:0]  alu_op;
    logic [7:0]   md_op;
    logic [6:0]   ld_op;
    logic [4:0]   st_op;
    logic [4:0]   src_sel;
    logic         gr_we;
    logic [4:0]   dest;
    logic [15:0]  imm;
    logic [31:0]  rs_value;
    logic [31:0]  rt_value;
    logic [31:0]  pc;

    assign {alu_op, md_op, ld_op, st_op, src_sel, gr_we, dest, imm,
            rs_value, rt_value, pc} = es_bus;

    logic op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic op_sw, op_sb, op_sh, op_swl, op_swr;
    logic is_div, is_ld, is_st;

    assign {op_mult, op_multu, op_div, op_divu,
            op_mfhi, op_mflo, op_mthi, op_mtlo} = md_op;
    assign {op_sw, op_sb, op_sh, op_swl, op_swr} = st_op;
    assign is_div = op_div | op_divu;
    assign is_ld  = |ld_op;
    assign is_st  = |st_op;

    // ---------------- pipeline register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid <= 1'b0;
            es_bus   <= '0;
        end else begin
            if (es_allowin) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid && es_allowin) begin
                es_bus <= ds_to_es_bus;
            end
        end
    end

    // ---------------- operands and ALU ----------------
    logic [31:0] simm;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] sra_res;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] alu_result;
    logic [31:0] ea;

    assign simm = {{16{imm[15]}}, imm};
    assign src1 = src_sel[4] ? {27'b0, imm[10:6]} :
                  src_sel[3] ? pc : rs_value;
    assign src2 = src_sel[2] ? simm :
                  src_sel[1] ? {16'b0, imm} :
                  src_sel[0] ? 32'd8 : rt_value;

    // kept as separate signals so signedness is not lost inside the OR-mux
    assign sra_res  = $signed(src2) >>> src1[4:0];
    assign slt_res  = $signed(src1) < $signed(src2);
    assign sltu_res = src1 < src2;

    always_comb begin
        alu_result = 32'b0;
        if (alu_op[11]) alu_result = alu_result | (src1 + src2);
        if (alu_op[10]) alu_result = alu_result | (src1 - src2);
        if (alu_op[9])  alu_result = alu_result | {31'b0, slt_res};
        if (alu_op[8])  alu_result = alu_result | {31'b0, sltu_res};
        if (alu_op[7])  alu_result = alu_result | (src1 & src2);
        if (alu_op[6])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[5])  alu_result = alu_result | (src1 | src2);
        if (alu_op[4])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[3])  alu_result = alu_result | (src2 << src1[4:0]);
        if (alu_op[2])  alu_result = alu_result | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_result = alu_result | sra_res;
        if (alu_op[0])  alu_result = alu_result | {src2[15:0], 16'b0};
    end

    assign ea = rs_value + simm;

    // ---------------- multiplier ----------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a   = {{32{op_mult & rs_value[31]}}, rs_value};
    assign mul_b   = {{32{op_mult & rt_value[31]}}, rt_value};
    assign product = mul_a * mul_b;

    // ---------------- divider ----------------
    logic [1:0]  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_r;
    logic [31:0] div_q;
    logic [31:0] div_d;
    logic        div_sq;
    logic        div_sr;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        div_by_zero;

    assign div_shift = {div_r, div_q[31]};
    assign div_diff  = div_shift - {1'b0, div_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= 5'd0;
            div_r     <= 32'b0;
            div_q     <= 32'b0;
            div_d     <= 32'b0;
            div_sq    <= 1'b0;
            div_sr    <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (es_valid && is_div) begin
                        div_state <= DIV_BUSY;
                        div_cnt   <= 5'd0;
                        div_r     <= 32'b0;
                        div_q     <= (op_div && rs_value[31]) ? 32'd0 - rs_value : rs_value;
                        div_d     <= (op_div && rt_value[31]) ? 32'd0 - rt_value : rt_value;
                        div_sq    <= op_div & (rs_value[31] ^ rt_value[31]);
                        div_sr    <= op_div & rs_value[31];
                    end
                end
                DIV_BUSY: begin
                    if (!div_diff[32]) begin
                        div_r <= div_diff[31:0];
                        div_q <= {div_q[30:0], 1'b1};
                    end else begin
                        div_r <= div_shift[31:0];
                        div_q <= {div_q[30:0], 1'b0};
                    end
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (es_leave) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    assign quot_fix    = div_sq ? 32'd0 - div_q : div_q;
    assign rem_fix     = div_sr ? 32'd0 - div_r : div_r;
    assign div_by_zero = (rt_value == 32'b0);

    // ---------------- HI/LO ----------------
    logic [31:0] hi;
    logic [31:0] lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'b0;
            lo <= 32'b0;
        end else if (es_leave) begin
            if (op_mult || op_multu) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end else if (is_div) begin
                // divide by zero reports the raw dividend, no sign fix-up
                if (div_by_zero) begin
                    hi <= rs_value;
                    lo <= 32'hFFFF_FFFF;
                end else begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end
            end else if (op_mthi) begin
                hi <= rs_value;
            end else if (op_mtlo) begin
                lo <= rs_value;
            end
        end
    end

    // ---------------- handshake ----------------
    assign es_ready_go    = !is_div || (div_state == DIV_DONE);
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_leave       = es_to_ms_valid && ms_allowin;

    // ---------------- store lanes ----------------
    logic [1:0]  addr_low;
    logic [3:0]  st_wen;
    logic [31:0] st_wdata;

    assign addr_low = ea[1:0];

    always_comb begin
        st_wen   = 4'b0000;
        st_wdata = rt_value;
        if (op_sw) begin
            st_wen = 4'b1111;
        end else if (op_sb) begin
            st_wen   = 4'b0001 << addr_low;
            st_wdata = {4{rt_value[7:0]}};
        end else if (op_sh) begin
            st_wen   = addr_low[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{rt_value[15:0]}};
        end else if (op_swl) begin
            case (addr_low)
                2'd0:    st_wen = 4'b0001;
                2'd1:    st_wen = 4'b0011;
                2'd2:    st_wen = 4'b0111;
                default: st_wen = 4'b1111;
            endcase
            st_wdata = rt_value >> {~addr_low, 3'b000};
        end else if (op_swr) begin
            st_wen   = 4'b1111 << addr_low;
            st_wdata = rt_value << {addr_low, 3'b000};
        end
    end

    assign data_sram_en    = es_valid && es_ready_go && ms_allowin && (is_ld || is_st);
    assign data_sram_wen   = data_sram_en ? st_wen : 4'b0000;
    assign data_sram_addr  = {ea[31:2], 2'b00};
    assign data_sram_wdata = st_wdata;

    // ---------------- outputs to memory stage / decode ----------------
    logic [31:0] result;

    assign result = op_mfhi ? hi : op_mflo ? lo : alu_result;

    assign es_to_ms_bus = {is_ld, addr_low, ld_op[5:0], gr_we, dest, result, pc};
    assign es_fwd_bus   = {es_valid && gr_we, dest, is_ld, result};

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against a behavioural model
// of the ALU, HI/LO arithmetic and store byte-lane rules.
`timescale 1ns/1ps
module tb_exe_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ms_allowin = 1'b1;
    logic         ds_to_es_valid = 1'b0;
    logic [154:0] ds_to_es_bus = '0;
    logic         es_allowin;
    logic         es_to_ms_valid;
    logic [78:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [38:0]  es_fwd_bus;
    logic         es_valid;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 32'b0;
    logic [31:0] m_lo = 32'b0;

    localparam logic [7:0] MD_MULT  = 8'h80;
    localparam logic [7:0] MD_MULTU = 8'h40;
    localparam logic [7:0] MD_DIV   = 8'h20;
    localparam logic [7:0] MD_DIVU  = 8'h10;
    localparam logic [7:0] MD_MFHI  = 8'h08;
    localparam logic [7:0] MD_MFLO  = 8'h04;
    localparam logic [7:0] MD_MTHI  = 8'h02;
    localparam logic [7:0] MD_MTLO  = 8'h01;
    localparam logic [4:0] SEL_SA   = 5'h10;
    localparam logic [4:0] SEL_PC   = 5'h08;
    localparam logic [4:0] SEL_SIMM = 5'h04;
    localparam logic [4:0] SEL_ZIMM = 5'h02;
    localparam logic [4:0] SEL_8    = 5'h01;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_fwd_bus(es_fwd_bus), .es_valid(es_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [154:0] mk(input logic [11:0] alu, input logic [7:0] md,
                                        input logic [6:0] ld, input logic [4:0] st,
                                        input logic [4:0] sel, input logic we,
                                        input logic [4:0] dest, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        return {alu, md, ld, st, sel, we, dest, imm, rs, rt, pc};
    endfunction

    // ops in order: add sub slt sltu and nor or xor sll srl sra lui
    function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(a[4:0]);
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << sh;
            9:  return b >> sh;
            10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            default: return {b[15:0], 16'h0000};
        endcase
    endfunction

    // kinds: 0 sw, 1 sb, 2 sh, 3 swl, 4 swr
    function automatic void ref_store(input int kind, input int low, input logic [31:0] rt,
                                      output logic [3:0] wen, output logic [31:0] wd);
        wen = 4'b0000;
        wd  = rt;
        case (kind)
            0: wen = 4'b1111;
            1: begin wen[low] = 1'b1; wd = {4{rt[7:0]}}; end
            2: begin wen = (low >= 2) ? 4'b1100 : 4'b0011; wd = {2{rt[15:0]}}; end
            3: begin
                for (int i = 0; i < 4; i++) wen[i] = (i <= low);
                wd = rt >> (8 * (3 - low));
            end
            default: begin
                for (int i = 0; i < 4; i++) wen[i] = (i >= low);
                wd = rt << (8 * low);
            end
        endcase
    endfunction

    task automatic send(input logic [154:0] b);
        int n;
        n = 0;
        ds_to_es_bus   = b;
        ds_to_es_valid = 1'b1;
        while (es_allowin !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL send_timeout es_allowin=%b required 1", es_allowin);
        end
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
    endtask

    task automatic drain();
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (es_valid !== 1'b0 || es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake valid=%b allowin=%b to_ms=%b required 0 1 0",
                     es_valid, es_allowin, es_to_ms_valid);
        end
        tests++;
        if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0 || es_fwd_bus[38] !== 1'b0) begin
            fails++;
            $display("FAIL reset_sram en=%b wen=%b fwd_v=%b required 0 0000 0",
                     data_sram_en, data_sram_wen, es_fwd_bus[38]);
        end
        tests++;
        if (es_to_ms_bus !== 79'b0) begin
            fails++;
            $display("FAIL reset_bus got %h required 0", es_to_ms_bus);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        m_hi = 32'b0; m_lo = 32'b0;
        send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd2, 16'h0, 32'h0, 32'h0, 32'h100));
        tests++;
        if (es_to_ms_bus[63:32] !== m_hi) begin
            fails++;
            $display("FAIL reset_hi got %h required %h", es_to_ms_bus[63:32], m_hi);
        end
        send(mk(12'h0, MD_MFLO, 7'h0, 5'h0, 5'h0, 1'b1, 5'd2, 16'h0, 32'h0, 32'h0, 32'h104));
        tests++;
        if (es_to_ms_bus[63:32] !== m_lo) begin
            fails++;
            $display("FAIL reset_lo got %h required %h", es_to_ms_bus[63:32], m_lo);
        end
    endtask

    task automatic test_add();
        send(mk(12'h800, 8'h0, 7'h0, 5'h0, SEL_SIMM, 1'b1, 5'd5, 16'd1,
                32'h7FFF_FFFF, 32'h0, 32'hBFC0_0000));
        tests++;
        if (es_valid !== 1'b1 || es_to_ms_valid !== 1'b1) begin
            fails++;
            $display("FAIL add_valid valid=%b to_ms=%b required 1 1", es_valid, es_to_ms_valid);
        end
        tests++;
        if (es_to_ms_bus[63:32] !== 32'h8000_0000) begin
            fails++;
            $display("FAIL add_result got %h required 80000000", es_to_ms_bus[63:32]);
        end
        tests++;
        if (es_fwd_bus !== {1'b1, 5'd5, 1'b0, 32'h8000_0000}) begin
            fails++;
            $display("FAIL add_fwd got %h required %h", es_fwd_bus, {1'b1, 5'd5, 1'b0, 32'h8000_0000});
        end
    endtask

    task automatic test_alu_random();
        for (int it = 0; it < 40; it++) begin
            int k, s1, s2;
            logic [31:0] rs, rt, pc, a, b, exp, ea;
            logic [15:0] imm;
            logic [4:0]  sel, dest;
            logic        we;
            k = $urandom_range(0, 11);
            s1 = $urandom_range(0, 2);
            s2 = $urandom_range(0, 3);
            rs = $urandom; rt = $urandom; pc = $urandom & 32'hFFFF_FFFC;
            imm = 16'($urandom); dest = 5'($urandom); we = 1'($urandom);
            sel = 5'h0; a = rs; b = rt;
            if (s1 == 1) begin sel = sel | SEL_SA; a = {27'b0, imm[10:6]}; end
            else if (s1 == 2) begin sel = sel | SEL_PC; a = pc; end
            case (s2)
                1: begin sel = sel | SEL_SIMM; b = {{16{imm[15]}}, imm}; end
                2: begin sel = sel | SEL_ZIMM; b = {16'b0, imm}; end
                3: begin sel = sel | SEL_8; b = 32'd8; end
                default: ;
            endcase
            exp = ref_alu(k, a, b);
            ea  = rs + {{16{imm[15]}}, imm};
            send(mk(12'h800 >> k, 8'h0, 7'h0, 5'h0, sel, we, dest, imm, rs, rt, pc));
            tests++;
            if (es_to_ms_valid !== 1'b1 || data_sram_en !== 1'b0) begin
                fails++;
                $display("FAIL alu_valid op=%0d to_ms=%b en=%b required 1 0", k, es_to_ms_valid, data_sram_en);
            end
            tests++;
            if (es_to_ms_bus !== {1'b0, ea[1:0], 6'b0, we, dest, exp, pc}) begin
                fails++;
                $display("FAIL alu_bus op=%0d a=%h b=%h got result %h required %h (bus %h)",
                         k, a, b, es_to_ms_bus[63:32], exp, es_to_ms_bus);
            end
            tests++;
            if (es_fwd_bus !== {we, dest, 1'b0, exp}) begin
                fails++;
                $display("FAIL alu_fwd op=%0d got %h required %h", k, es_fwd_bus, {we, dest, 1'b0, exp});
            end
        end
    endtask

    task automatic test_store();
        int kinds[2];
        logic [31:0] d_rs[2];
        logic [15:0] d_imm[2];
        logic [31:0] d_rt[2];
        kinds[0] = 1; d_rs[0] = 32'h1000_0000; d_imm[0] = 16'd2; d_rt[0] = 32'h1234_56AB;
        kinds[1] = 4; d_rs[1] = 32'h2000_0000; d_imm[1] = 16'd1; d_rt[1] = 32'h1122_3344;
        drain();
        for (int it = 0; it < 26; it++) begin
            int kind;
            logic [31:0] rs, rt, ea, exp_wd;
            logic [15:0] imm;
            logic [3:0]  exp_wen;
            logic [6:0]  ld;
            logic [4:0]  st;
            if (it < 2) begin
                kind = kinds[it]; rs = d_rs[it]; imm = d_imm[it]; rt = d_rt[it];
            end else begin
                kind = $urandom_range(0, 11); rs = $urandom; imm = 16'($urandom); rt = $urandom;
            end
            ea = rs + {{16{imm[15]}}, imm};
            ld = 7'h0; st = 5'h0;
            exp_wen = 4'b0000; exp_wd = 32'h0;
            if (kind < 5) begin
                st = 5'b10000 >> kind;
                ref_store(kind, int'(ea[1:0]), rt, exp_wen, exp_wd);
            end else begin
                ld = 7'b1000000 >> (kind - 5);
            end
            send(mk(12'h0, 8'h0, ld, st, SEL_SIMM, kind >= 5, 5'd9, imm, rs, rt, 32'h400));
            tests++;
            if (data_sram_en !== 1'b1 || data_sram_addr !== {ea[31:2], 2'b00}) begin
                fails++;
                $display("FAIL mem_req kind=%0d en=%b addr=%h required 1 %h",
                         kind, data_sram_en, data_sram_addr, {ea[31:2], 2'b00});
            end
            tests++;
            if (data_sram_wen !== exp_wen) begin
                fails++;
                $display("FAIL mem_wen kind=%0d low=%0d got %b required %b", kind, ea[1:0], data_sram_wen, exp_wen);
            end
            if (kind < 5) begin
                tests++;
                if (data_sram_wdata !== exp_wd) begin
                    fails++;
                    $display("FAIL mem_wdata kind=%0d low=%0d got %h required %h",
                             kind, ea[1:0], data_sram_wdata, exp_wd);
                end
            end
            tests++;
            if (es_to_ms_bus[78:70] !== {kind >= 5, ea[1:0], ld[5:0]}) begin
                fails++;
                $display("FAIL mem_bus kind=%0d got %b required %b", kind, es_to_ms_bus[78:70],
                         {kind >= 5, ea[1:0], ld[5:0]});
            end
        end
        drain();
        ms_allowin = 1'b0;
        send(mk(12'h0, 8'h0, 7'h0, 5'b10000, SEL_SIMM, 1'b0, 5'd0, 16'h8, 32'h3000_0000, 32'hCAFE_F00D, 32'h0));
        for (int c = 0; c < 2; c++) begin
            tests++;
            if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0 || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0) begin
                fails++;
                $display("FAIL store_stall cycle %0d en=%b wen=%b to_ms=%b allowin=%b required 0 0000 1 0",
                         c, data_sram_en, data_sram_wen, es_to_ms_valid, es_allowin);
            end
            @(posedge clk); #1;
        end
        ms_allowin = 1'b1;
        #1;
        tests++;
        if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b1111 || data_sram_wdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL store_release en=%b wen=%b wdata=%h required 1 1111 cafef00d",
                     data_sram_en, data_sram_wen, data_sram_wdata);
        end
        drain();
    endtask

    task automatic test_mult();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] rs, rt;
            logic [63:0] p;
            longint x, y;
            logic sgn;
            if (it == 0) begin sgn = 1'b0; rs = 32'hFFFF_FFFF; rt = 32'd2; end
            else begin sgn = 1'($urandom); rs = $urandom; rt = $urandom; end
            if (sgn) begin x = $signed(rs); y = $signed(rt); p = x * y; end
            else p = {32'b0, rs} * {32'b0, rt};
            send(mk(12'h0, sgn ? MD_MULT : MD_MULTU, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, rs, rt, 32'h200));
            m_hi = p[63:32]; m_lo = p[31:0];
            send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd3, 16'h0, 32'h0, 32'h0, 32'h204));
            tests++;
            if (es_to_ms_bus[63:32] !== m_hi || es_fwd_bus[31:0] !== m_hi) begin
                fails++;
                $display("FAIL mult_hi sgn=%b %h*%h got %h required %h", sgn, rs, rt, es_to_ms_bus[63:32], m_hi);
            end
            send(mk(12'h0, MD_MFLO, 7'h0, 5'h0, 5'h0, 1'b1, 5'd3, 16'h0, 32'h0, 32'h0, 32'h208));
            tests++;
            if (es_to_ms_bus[63:32] !== m_lo) begin
                fails++;
                $display("FAIL mult_lo sgn=%b %h*%h got %h required %h", sgn, rs, rt, es_to_ms_bus[63:32], m_lo);
            end
        end
        for (int it = 0; it < 3; it++) begin
            logic [31:0] v, w;
            v = $urandom; w = $urandom;
            send(mk(12'h0, MD_MTHI, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, v, 32'h0, 32'h300));
            m_hi = v;
            send(mk(12'h0, MD_MTLO, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, w, 32'h0, 32'h304));
            m_lo = w;
            send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd4, 16'h0, 32'h0, 32'h0, 32'h308));
            tests++;
            if (es_to_ms_bus[63:32] !== m_hi) begin
                fails++;
                $display("FAIL mthi got %h required %h", es_to_ms_bus[63:32], m_hi);
            end
            send(mk(12'h0, MD_MFLO, 7'h0, 5'h0, 5'h0, 1'b1, 5'd4, 16'h0, 32'h0, 32'h0, 32'h30C));
            tests++;
            if (es_to_ms_bus[63:32] !== m_lo) begin
                fails++;
                $display("FAIL mtlo got %h required %h", es_to_ms_bus[63:32], m_lo);
            end
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt, input int stall);
        logic [31:0] q, r;
        longint x, y;
        if (rt == 32'b0) begin q = 32'hFFFF_FFFF; r = rs; end
        else if (sgn) begin
            x = $signed(rs); y = $signed(rt);
            q = 32'(x / y); r = 32'(x % y);
        end else begin
            q = rs / rt; r = rs % rt;
        end
        drain();
        ms_allowin = (stall == 0);
        send(mk(12'h0, sgn ? MD_DIV : MD_DIVU, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, rs, rt, 32'h0040_0000));
        for (int c = 0; c < 34; c++) begin
            tests++;
            if (es_to_ms_valid !== 1'(c == 33)) begin
                fails++;
                $display("FAIL div_ready_go cycle %0d got %b required %b", c, es_to_ms_valid, c == 33);
            end
            if (c < 33) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < stall; i++) begin
            tests++;
            if (es_valid !== 1'b1 || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0 || data_sram_en !== 1'b0) begin
                fails++;
                $display("FAIL div_stall_hold cycle %0d valid=%b to_ms=%b allowin=%b en=%b required 1 1 0 0",
                         i, es_valid, es_to_ms_valid, es_allowin, data_sram_en);
            end
            @(posedge clk); #1;
        end
        ms_allowin = 1'b1;
        m_lo = q; m_hi = r;
        send(mk(12'h0, MD_MFLO, 7'h0, 5'h0, 5'h0, 1'b1, 5'd6, 16'h0, 32'h0, 32'h0, 32'h0040_0004));
        tests++;
        if (es_to_ms_bus[63:32] !== m_lo) begin
            fails++;
            $display("FAIL div_lo sgn=%b %h/%h got %h required %h", sgn, rs, rt, es_to_ms_bus[63:32], m_lo);
        end
        send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd6, 16'h0, 32'h0, 32'h0, 32'h0040_0008));
        tests++;
        if (es_to_ms_bus[63:32] !== m_hi) begin
            fails++;
            $display("FAIL div_hi sgn=%b %h/%h got %h required %h", sgn, rs, rt, es_to_ms_bus[63:32], m_hi);
        end
    endtask

    task automatic test_div();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b0, 32'd5, 32'd0, 10);
        run_div(1'b1, 32'hFFFF_FFF7, 32'd0, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        for (int it = 0; it < 4; it++) begin
            logic [31:0] rt;
            rt = (it % 2 == 0) ? 32'($urandom_range(1, 300)) - 32'd150 : $urandom;
            run_div(1'($urandom), $urandom, rt, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_div();
        send(mk(12'h0, MD_MTHI, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, 32'hAAAA_5555, 32'h0, 32'h500));
        m_hi = 32'hAAAA_5555;
        send(mk(12'h0, MD_MTLO, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, 32'h0000_1234, 32'h0, 32'h504));
        m_lo = 32'h0000_1234;
        send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd7, 16'h0, 32'h0, 32'h0, 32'h508));
        tests++;
        if (es_to_ms_bus[63:32] !== m_hi) begin
            fails++;
            $display("FAIL pre_reset_hi got %h required %h", es_to_ms_bus[63:32], m_hi);
        end
        send(mk(12'h0, MD_DIV, 7'h0, 5'h0, 5'h0, 1'b0, 5'd0, 16'h0, 32'd1000, 32'd7, 32'h50C));
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        m_hi = 32'b0; m_lo = 32'b0;
        tests++;
        if (es_valid !== 1'b0 || es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0 ||
            es_fwd_bus[38] !== 1'b0 || data_sram_en !== 1'b0) begin
            fails++;
            $display("FAIL mid_div_reset valid=%b allowin=%b to_ms=%b fwd_v=%b en=%b required 0 1 0 0 0",
                     es_valid, es_allowin, es_to_ms_valid, es_fwd_bus[38], data_sram_en);
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        send(mk(12'h0, MD_MFHI, 7'h0, 5'h0, 5'h0, 1'b1, 5'd7, 16'h0, 32'h0, 32'h0, 32'h510));
        tests++;
        if (es_to_ms_bus[63:32] !== m_hi) begin
            fails++;
            $display("FAIL post_reset_hi got %h required %h", es_to_ms_bus[63:32], m_hi);
        end
        send(mk(12'h0, MD_MFLO, 7'h0, 5'h0, 5'h0, 1'b1, 5'd7, 16'h0, 32'h0, 32'h0, 32'h514));
        tests++;
        if (es_to_ms_bus[63:32] !== m_lo) begin
            fails++;
            $display("FAIL post_reset_lo got %h required %h", es_to_ms_bus[63:32], m_lo);
        end
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_alu_random();
        test_store();
        test_mult();
        test_div();
        test_reset_mid_div();
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
